dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 65 ++++++
 rtl/dmem_ram.sv | 24 ++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and lane helpers for the MEM-stage data-memory responder.
package dmem_pkg;

    localparam logic [1:0] BS_WORD = 2'b00;
    localparam logic [1:0] BS_BYTE = 2'b01;
    localparam logic [1:0] BS_HALF = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RESP,
        RMW_RD,
        RMW_WR
    } state_t;

    // Encoding 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_sel(input logic [1:0] sel);
        return (sel == 2'b11) ? BS_WORD : sel;
    endfunction

    function automatic logic lane_aligned(input logic [1:0] lane, input logic [1:0] sel);
        logic ok;
        case (sel)
            BS_BYTE: ok = 1'b1;
            BS_HALF: ok = ~lane[0];
            default: ok = (lane == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  sel,
                                                 input logic        sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sel)
            BS_BYTE: r = {{24{sext & b[7]}}, b};
            BS_HALF: r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  sel);
        logic [31:0] r;
        r = word;
        case (sel)
            BS_BYTE: r[{lane, 3'b000} +: 8] = data[7:0];
            BS_HALF: begin
                if (lane[1]) r[31:16] = data[15:0];
                else         r[15:0]  = data[15:0];
            end
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM, one-cycle read latency, write-first; no reset on contents.
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: word store 0 stall, load 2 stall + RESP, sub-word store 2 stall (RMW).
// Stall holds the pipeline; illegal accesses set sticky AddrErr, skip the RAM and return 0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  ByteSel,
    input  logic        SignedLoad,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AddrErr
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [30:0] DEPTH_L = 31'(DEPTH_WORDS);

    state_t      state, state_nxt;
    logic [29:0] word_off;
    logic [AW-1:0] word_idx;
    logic [1:0]  sel;
    logic        legal;
    logic        req;

    logic [AW-1:0] acc_idx;
    logic [1:0]  acc_lane;
    logic [1:0]  acc_sel;
    logic        acc_sext;
    logic [31:0] rmw_word;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    // Word offset from the base; addresses below the base wrap and fail the range check.
    assign word_off = Address[31:2] - ADDR_BASE[31:2];
    assign word_idx = word_off[AW-1:0];
    assign sel      = norm_sel(ByteSel);
    assign legal    = lane_aligned(Address[1:0], sel) && ({1'b0, word_off} < DEPTH_L);
    assign req      = MemRead | MemWrite;

    always_comb begin
        state_nxt = state;
        Stall     = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = word_idx;
        ram_wdata = WriteData;
        case (state)
            IDLE: begin
                if (req && legal) begin
                    if (MemWrite && sel == BS_WORD) begin
                        ram_we = 1'b1;
                    end else if (MemWrite) begin
                        Stall     = 1'b1;
                        state_nxt = RMW_RD;
                    end else begin
                        Stall     = 1'b1;
                        state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                Stall     = 1'b1;
                state_nxt = RESP;
            end
            RESP: state_nxt = IDLE;
            RMW_RD: begin
                Stall     = 1'b1;
                state_nxt = RMW_WR;
            end
            RMW_WR: begin
                ram_we    = 1'b1;
                ram_addr  = acc_idx;
                ram_wdata = rmw_word;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A reset edge must never commit a write, including a pending RMW.
        ram_we = ram_we & Reset;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= IDLE;
            ReadData <= '0;
            AddrErr  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req && !legal) begin
                AddrErr  <= 1'b1;
                ReadData <= '0;
            end else if (state == RD_WAIT) begin
                ReadData <= lane_extract(ram_rdata, acc_lane, acc_sel, acc_sext);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (state == IDLE && req && legal) begin
            acc_idx  <= word_idx;
            acc_lane <= Address[1:0];
            acc_sel  <= sel;
            acc_sext <= SignedLoad;
        end
        // WriteData and ByteSel are re-sampled here rather than at request time.
        if (state == RMW_RD) begin
            rmw_word <= lane_merge(ram_rdata, WriteData, acc_lane, sel);
        end
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (Clock),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_dmem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  ByteSel = 2'b00;
    logic        SignedLoad = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Stall;
    logic        AddrErr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [DEPTH];
    logic        ref_err;
    logic [31:0] ref_rd;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_BASE  (BASE)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ByteSel   (ByteSel),
        .SignedLoad(SignedLoad),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .AddrErr   (AddrErr)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: plain arithmetic over a word array. Returns expected stall cycles.
    task automatic model_op(input logic rd, input logic wr, input logic [1:0] bs, input logic sx,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output int exp_st, output logic is_load);
        int          sz, sh, idx;
        logic [31:0] off, w, v, lmask;
        sz = (bs == 2'b01) ? 1 : (bs == 2'b10) ? 2 : 4;
        lmask = (sz == 1) ? 32'hFF : 32'hFFFF;
        off = addr - BASE;
        exp_st = 0;
        is_load = 1'b0;
        if (!rd && !wr) begin
            exp_st = 0;
        end else if ((addr % sz) != 0 || (off / 4) >= DEPTH) begin
            ref_err = 1'b1;
            ref_rd  = '0;
        end else begin
            idx = int'(off / 4);
            sh  = 8 * int'(addr % 4);
            w   = ref_mem[idx];
            if (wr) begin
                if (sz == 4) begin
                    ref_mem[idx] = wd;
                end else begin
                    ref_mem[idx] = (w & ~(lmask << sh)) | ((wd & lmask) << sh);
                    exp_st = 2;
                end
            end else begin
                exp_st = 2;
                if (sz == 4) begin
                    v = w;
                end else begin
                    v = (w >> sh) & lmask;
                    if (sx && v[8*sz-1]) v = v | ~lmask;
                end
                ref_rd  = v;
                is_load = 1'b1;
            end
        end
    endtask

    // Presents one request and holds it until Stall drops; called at posedge+1.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] bs, input logic sx,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output int stalls, output logic [31:0] rd_done);
        bit done;
        int cyc;
        MemRead = rd; MemWrite = wr; ByteSel = bs; SignedLoad = sx;
        Address = addr; WriteData = wd;
        stalls = 0; rd_done = '0; done = 0; cyc = 0;
        while (!done && cyc < 10) begin
            @(negedge Clock);
            if (Stall == 1'b0) begin
                rd_done = ReadData;
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge Clock); #1;
            cyc++;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL access_timeout addr=%h: Stall never dropped within 10 cycles", addr);
        end
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [1:0] bs, input logic sx,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int act_st, output int exp_st,
                          output logic [31:0] act_done, output logic [31:0] act_after,
                          output logic is_load);
        model_op(rd, wr, bs, sx, addr, wd, exp_st, is_load);
        do_access(rd, wr, bs, sx, addr, wd, act_st, act_done);
        act_after = ReadData;
    endtask

    task automatic idle_cycle();
        @(posedge Clock); #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        n_cmp++; if (ReadData !== 32'h0) begin n_bad++; $display("FAIL reset_readdata got=%h want=0", ReadData); end
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b want=0", Stall); end
        n_cmp++; if (AddrErr !== 1'b0) begin n_bad++; $display("FAIL reset_addrerr got=%b want=0", AddrErr); end
        Reset = 1'b1;
        ref_err = 1'b0; ref_rd = '0;
        idle_cycle();
    endtask

    task automatic test_word_store_load();
        int as, es; logic [31:0] ad, aa; logic ld;
        run_op(0, 1, 2'b00, 0, 32'h10, 32'hDEADBEEF, as, es, ad, aa, ld);
        n_cmp++; if (as !== 0) begin n_bad++; $display("FAIL wstore_stall got=%0d want=0", as); end
        run_op(1, 0, 2'b00, 0, 32'h10, 32'h0, as, es, ad, aa, ld);
        n_cmp++; if (as !== 2) begin n_bad++; $display("FAIL wload_stall got=%0d want=2", as); end
        n_cmp++; if (ad !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wload_resp got=%h want=deadbeef", ad); end
        idle_cycle();
    endtask

    task automatic test_byte_rmw();
        int as, es; logic [31:0] ad, aa; logic ld;
        run_op(0, 1, 2'b01, 0, 32'h12, 32'h1234_5655, as, es, ad, aa, ld);
        n_cmp++; if (as !== 2) begin n_bad++; $display("FAIL rmw_stall got=%0d want=2", as); end
        run_op(1, 0, 2'b00, 0, 32'h10, 32'h0, as, es, ad, aa, ld);
        n_cmp++; if (ad !== 32'hDE55BEEF) begin n_bad++; $display("FAIL rmw_result got=%h want=de55beef", ad); end
        idle_cycle();
    endtask

    task automatic test_signed_loads();
        int as, es; logic [31:0] ad, aa; logic ld;
        run_op(1, 0, 2'b10, 1, 32'h10, 32'h0, as, es, ad, aa, ld);
        n_cmp++; if (ad !== 32'hFFFFBEEF) begin n_bad++; $display("FAIL half_signed got=%h want=ffffbeef", ad); end
        run_op(1, 0, 2'b10, 0, 32'h10, 32'h0, as, es, ad, aa, ld);
        n_cmp++; if (ad !== 32'h0000BEEF) begin n_bad++; $display("FAIL half_unsigned got=%h want=0000beef", ad); end
        run_op(1, 0, 2'b01, 1, 32'h13, 32'h0, as, es, ad, aa, ld);
        n_cmp++; if (ad !== 32'hFFFFFFDE) begin n_bad++; $display("FAIL byte_signed got=%h want=ffffffde", ad); end
        n_cmp++; if (aa !== 32'hFFFFFFDE) begin n_bad++; $display("FAIL byte_hold got=%h want=ffffffde", aa); end
        idle_cycle();
    endtask

    task automatic test_random();
        int as, es; logic [31:0] ad, aa, addr; logic ld, rd, wr, sx; logic [1:0] bs; int op;
        for (int i = 16; i < 32; i++) begin
            run_op(0, 1, 2'b00, 0, 32'(i * 4), $urandom, as, es, ad, aa, ld);
        end
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 7);
            rd = (op != 1 && op != 5);
            wr = (op == 1 || op == 2 || op == 5);
            bs = 2'($urandom_range(0, 3));
            sx = 1'($urandom_range(0, 1));
            addr = (op == 7) ? 32'h100 + $urandom_range(0, 15) : 32'h40 + $urandom_range(0, 63);
            run_op(rd, wr, bs, sx, addr, $urandom, as, es, ad, aa, ld);
            n_cmp++; if (as !== es) begin n_bad++; $display("FAIL rnd_stall op%0d addr=%h got=%0d want=%0d", i, addr, as, es); end
            if (ld) begin
                n_cmp++; if (ad !== ref_rd) begin n_bad++; $display("FAIL rnd_load op%0d addr=%h got=%h want=%h", i, addr, ad, ref_rd); end
            end
            n_cmp++; if (aa !== ref_rd) begin n_bad++; $display("FAIL rnd_readdata op%0d got=%h want=%h", i, aa, ref_rd); end
            n_cmp++; if (AddrErr !== ref_err) begin n_bad++; $display("FAIL rnd_addrerr op%0d got=%b want=%b", i, AddrErr, ref_err); end
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
    endtask

    task automatic test_errors();
        int as, es; logic [31:0] ad, aa; logic ld;
        run_op(0, 1, 2'b00, 0, 32'h0, 32'h12345678, as, es, ad, aa, ld);
        run_op(1, 0, 2'b00, 0, 32'h10, 32'h0, as, es, ad, aa, ld);
        run_op(1, 0, 2'b10, 1, 32'h11, 32'h0, as, es, ad, aa, ld);
        n_cmp++; if (as !== 0) begin n_bad++; $display("FAIL misalign_stall got=%0d want=0", as); end
        n_cmp++; if (aa !== 32'h0) begin n_bad++; $display("FAIL misalign_readdata got=%h want=0", aa); end
        n_cmp++; if (AddrErr !== 1'b1) begin n_bad++; $display("FAIL misalign_addrerr got=%b want=1", AddrErr); end
        run_op(0, 1, 2'b00, 0, BASE + 32'(4 * DEPTH), 32'h0BADF00D, as, es, ad, aa, ld);
        n_cmp++; if (as !== 0) begin n_bad++; $display("FAIL oob_stall got=%0d want=0", as); end
        run_op(1, 0, 2'b00, 0, 32'h0, 32'h0, as, es, ad, aa, ld);
        n_cmp++; if (ad !== 32'h12345678) begin n_bad++; $display("FAIL oob_ram_unchanged got=%h want=12345678", ad); end
        n_cmp++; if (AddrErr !== 1'b1) begin n_bad++; $display("FAIL oob_sticky got=%b want=1", AddrErr); end
        idle_cycle();
    endtask

    task automatic test_reset_mid_rmw();
        int as, es; logic [31:0] ad, aa; logic ld;
        MemWrite = 1'b1; ByteSel = 2'b01; Address = 32'h10; WriteData = 32'hAA;
        @(negedge Clock);
        n_cmp++; if (Stall !== 1'b1) begin n_bad++; $display("FAIL rmwrst_start_stall got=%b want=1", Stall); end
        @(posedge Clock); #1;
        Reset = 1'b0; MemWrite = 1'b0;
        @(posedge Clock); #1;
        @(negedge Clock);
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL rmwrst_stall got=%b want=0", Stall); end
        n_cmp++; if (AddrErr !== 1'b0) begin n_bad++; $display("FAIL rmwrst_addrerr got=%b want=0", AddrErr); end
        @(posedge Clock); #1;
        Reset = 1'b1;
        ref_err = 1'b0; ref_rd = '0;
        idle_cycle();
        run_op(1, 0, 2'b00, 0, 32'h10, 32'h0, as, es, ad, aa, ld);
        n_cmp++; if (ad !== 32'hDE55BEEF) begin n_bad++; $display("FAIL rmwrst_ram got=%h want=de55beef", ad); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        int as, es; logic [31:0] ad, aa, v; logic ld;
        v = $urandom;
        run_op(0, 1, 2'b00, 0, 32'h14, v, as, es, ad, aa, ld);
        run_op(1, 0, 2'b00, 0, 32'h10, 32'h0, as, es, ad, aa, ld);
        n_cmp++; if (as !== 2) begin n_bad++; $display("FAIL b2b_first_stall got=%0d want=2", as); end
        n_cmp++; if (ad !== 32'hDE55BEEF) begin n_bad++; $display("FAIL b2b_first_data got=%h want=de55beef", ad); end
        run_op(1, 0, 2'b00, 0, 32'h14, 32'h0, as, es, ad, aa, ld);
        n_cmp++; if (as !== 2) begin n_bad++; $display("FAIL b2b_second_stall got=%0d want=2", as); end
        n_cmp++; if (ad !== v) begin n_bad++; $display("FAIL b2b_second_data got=%h want=%h", ad, v); end
        run_op(0, 1, 2'b01, 0, 32'h15, 32'h77, as, es, ad, aa, ld);
        run_op(1, 0, 2'b00, 0, 32'h14, 32'h0, as, es, ad, aa, ld);
        n_cmp++; if (ad !== ref_rd) begin n_bad++; $display("FAIL b2b_rmw_then_load got=%h want=%h", ad, ref_rd); end
        idle_cycle();
    endtask

    initial begin
        ref_err = 1'b0;
        ref_rd  = '0;
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_signed_loads();
        test_random();
        test_errors();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
